filter_scheduler: RTL and testbench

Time-multiplexed controller for the first-order IIR filter path. It walks the sample ROM and feeds each sample through one shared multiply-accumulate engine, once per filter channel (channel 0 low-pass, channel 1 high-pass by default coefficient load). Per-channel coefficients and history live in this block. Offset-biased results leave through a ready/valid port to the output writer. It replaces per-channel filter instances, and a run has a defined start and end.

---
 rtl/filter_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_filter_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_scheduler.sv
// Time-multiplexed first-order IIR scheduler: walks the sample ROM and runs each sample
// through one shared MAC per channel, emitting offset-biased results over ready/valid.
module filter_scheduler #(
  parameter int          N_CH         = 2,
  parameter int          ADDR_W       = 15,
  parameter int          FRAC         = 16,
  parameter int          SAMPLE_COUNT = 20000,
  parameter logic [31:0] OUT_OFFSET   = 32'h003FFFFF,
  localparam int         CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       cfg_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | rom_addr presented to the ROM
  // WAIT  | ROM data valid, captured into x
  // B0    | acc = b0*x
  // B1    | acc += b1*x1
  // A1    | acc += a1*y1, result registered
  // OUT   | result offered until handshake
  // DONE  | one-cycle end-of-run pulse
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_B0, S_B1, S_A1, S_OUT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [CH_W-1:0]     c_q, c_d;
  logic [31:0]         x_q, x_d;
  logic [31:0]         x1_q, x1_d;
  logic [31:0]         y_q, y_d;
  logic [31:0]         out_data_q, out_data_d;
  logic [63:0]         acc_q, acc_d;
  logic [31:0]         b0_q [N_CH];
  logic [31:0]         b0_d [N_CH];
  logic [31:0]         b1_q [N_CH];
  logic [31:0]         b1_d [N_CH];
  logic [31:0]         a1_q [N_CH];
  logic [31:0]         a1_d [N_CH];
  logic [31:0]         y1_q [N_CH];
  logic [31:0]         y1_d [N_CH];

  logic [31:0]         mul_a, mul_b;
  logic [63:0]         prod;
  logic [63:0]         sum;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};

  assign rom_addr  = rom_addr_q;
  assign out_valid = (state_q == S_OUT);
  assign out_ch    = c_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    c_d        = c_q;
    x_d        = x_q;
    x1_d       = x1_q;
    y_d        = y_q;
    out_data_d = out_data_q;
    acc_d      = acc_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    a1_d       = a1_q;
    y1_d       = y1_q;
    mul_a      = '0;
    mul_b      = '0;
    sum        = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
          x1_d       = '0;
          for (int i = 0; i < N_CH; i++) y1_d[i] = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        x_d     = rom_q;
        c_d     = '0;
        state_d = S_B0;
      end
      S_B0: begin
        mul_a   = b0_q[c_q];
        mul_b   = x_q;
        acc_d   = prod;
        state_d = S_B1;
      end
      S_B1: begin
        mul_a   = b1_q[c_q];
        mul_b   = x1_q;
        acc_d   = acc_q + prod;
        state_d = S_A1;
      end
      S_A1: begin
        mul_a      = a1_q[c_q];
        mul_b      = y1_q[c_q];
        sum        = acc_q + prod;
        acc_d      = sum;
        y_d        = sum[FRAC+31:FRAC];
        out_data_d = sum[FRAC+31:FRAC] + OUT_OFFSET;
        state_d    = S_OUT;
      end
      S_OUT: begin
        y1_d[c_q] = y_q;
        if (out_ready) begin
          if (c_q != CH_W'(N_CH - 1)) begin
            c_d     = c_q + CH_W'(1);
            state_d = S_B0;
          end else begin
            x1_d = x_q;
            if (rom_addr_q == ADDR_W'(SAMPLE_COUNT - 1)) begin
              state_d = S_DONE;
            end else begin
              rom_addr_d = rom_addr_q + ADDR_W'(1);
              state_d    = S_FETCH;
            end
          end
        end
      end
      S_DONE: begin
        rom_addr_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Coefficient writes land only while idle (including the cycle start is accepted).
    if (cfg_we && !busy && (int'(cfg_ch) < N_CH)) begin
      case (cfg_sel)
        2'd0:    b0_d[cfg_ch] = cfg_data;
        2'd1:    b1_d[cfg_ch] = cfg_data;
        2'd2:    a1_d[cfg_ch] = cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      c_q        <= '0;
      x_q        <= '0;
      x1_q       <= '0;
      y_q        <= '0;
      out_data_q <= '0;
      acc_q      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        b0_q[i] <= '0;
        b1_q[i] <= '0;
        a1_q[i] <= '0;
        y1_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      c_q        <= c_d;
      x_q        <= x_d;
      x1_q       <= x1_d;
      y_q        <= y_d;
      out_data_q <= out_data_d;
      acc_q      <= acc_d;
      for (int i = 0; i < N_CH; i++) begin
        b0_q[i] <= b0_d[i];
        b1_q[i] <= b1_d[i];
        a1_q[i] <= a1_d[i];
        y1_q[i] <= y1_d[i];
      end
    end
  end

endmodule

// File: tb/tb_filter_scheduler.sv
// Scoreboard bench for filter_scheduler: directed runs push expected results into a queue,
// and a negedge monitor pops and compares on every output handshake.
module tb_filter_scheduler;
  localparam int ADDR_W = 15;
  localparam int SC     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              cfg_we = 1'b0;
  logic [0:0]        cfg_ch = '0;
  logic [1:0]        cfg_sel = '0;
  logic [31:0]       cfg_data = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_q = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [0:0]        out_ch;
  logic [31:0]       out_data;
  logic              busy, done;

  filter_scheduler #(.N_CH(2), .ADDR_W(ADDR_W), .FRAC(16), .SAMPLE_COUNT(SC),
                     .OUT_OFFSET(32'h003FFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .rom_addr(rom_addr), .rom_q(rom_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered ROM model: 0 -> 3*addr, 1 -> 0x100, 2 -> 0x80000000.
  int rom_mode = 0;
  always @(posedge clk) begin
    case (rom_mode)
      0:       rom_q <= 32'(3 * int'(rom_addr));
      1:       rom_q <= 32'h0000_0100;
      default: rom_q <= 32'h8000_0000;
    endcase
  end

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  function automatic int rel();
    return cyc - t0 + 1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic void push(int ch, logic [31:0] d, int c);
    exp_t e;
    e.ch = ch; e.data = d; e.cyc = c;
    sbq.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out: got ch %0d data %0h, expected no output", out_ch, out_data);
      end else begin
        e = sbq.pop_front();
        chk("out_ch", 64'(out_ch), 64'(e.ch));
        chk("out_data", 64'(out_data), 64'(e.data));
        if (e.cyc >= 0) chk("out_cycle", 64'(rel()), 64'(e.cyc));
      end
    end
  end

  task automatic cfg(int ch, int sel, logic [31:0] d);
    cfg_we = 1'b1; cfg_ch = 1'(ch); cfg_sel = 2'(sel); cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run(int exp_done, int stall_at, int stall_len, bit perturb,
                     bit cfg_start, int c_ch, int c_sel, logic [31:0] c_d);
    int          d_before;
    bit          seen;
    int          r;
    logic [31:0] snap_d;
    logic [ADDR_W-1:0] snap_a;
    d_before = done_cnt;
    snap_d = '0; snap_a = '0;
    start = 1'b1;
    if (cfg_start) begin
      cfg_we = 1'b1; cfg_ch = 1'(c_ch); cfg_sel = 2'(c_sel); cfg_data = c_d;
    end
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      r = rel();
      if (stall_len > 0) begin
        if (r == stall_at) begin
          out_ready = 1'b0; snap_d = out_data; snap_a = rom_addr;
        end else if (r > stall_at && r < stall_at + stall_len) begin
          chk("stall_data", 64'(out_data), 64'(snap_d));
          chk("stall_addr", 64'(rom_addr), 64'(snap_a));
          chk("stall_valid", 64'(out_valid), 64'd1);
        end else if (r == stall_at + stall_len) begin
          out_ready = 1'b1;
        end
      end
      if (perturb && r == 12) begin
        start = 1'b1; cfg_we = 1'b1; cfg_ch = 1'b0; cfg_sel = 2'd0; cfg_data = 32'h7FFF_FFFF;
      end
      if (perturb && r == 13) begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        chk("done_cycle", 64'(r), 64'(exp_done));
        chk("done_busy", 64'(busy), 64'd0);
        if (perturb) start = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done in 200 cycles, expected done at %0d", exp_done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_width", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_addr", 64'(rom_addr), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("still_idle", 64'(busy), 64'd0);
    chk("done_count", 64'(done_cnt - d_before), 64'd1);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ch"}, 64'(out_ch), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_addr"}, 64'(rom_addr), 64'd0);
  endtask

  logic [31:0] pt0 [4] = '{32'h003FFFFF, 32'h00400002, 32'h00400005, 32'h00400008};
  logic [31:0] pt1 [4] = '{32'h003FFFFF, 32'h00400002, 32'h00400002, 32'h00400002};
  logic [31:0] fb0 [4] = '{32'h004000FF, 32'h0040017F, 32'h004001BF, 32'h004001DF};

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Passthrough on ch0, differentiator on ch1.
    rom_mode = 0;
    cfg(0, 0, 32'h0001_0000);
    cfg(1, 0, 32'h0001_0000);
    cfg(1, 1, 32'hFFFF_0000);
    for (int k = 0; k < SC; k++) begin
      push(0, pt0[k], 6 + 10 * k);
      push(1, pt1[k], 10 + 10 * k);
    end
    run(41, 0, 0, 1'b0, 1'b0, 0, 0, '0);

    // Five-cycle stall on sample 1 channel 0.
    for (int k = 0; k < SC; k++) begin
      for (int c = 0; c < 2; c++) begin
        base = 6 + 10 * k + 4 * c;
        push(c, (c == 0) ? pt0[k] : pt1[k], (base >= 16) ? base + 5 : base);
      end
    end
    run(46, 16, 5, 1'b0, 1'b0, 0, 0, '0);

    // Config write and start mid-run are ignored; start in DONE cycle ignored too.
    for (int k = 0; k < SC; k++) begin
      push(0, pt0[k], 6 + 10 * k);
      push(1, pt1[k], 10 + 10 * k);
    end
    run(41, 0, 0, 1'b1, 1'b0, 0, 0, '0);

    // Mid-run reset: outputs and coefficients cleared, partial results dropped.
    push(0, 32'h003FFFFF, 6);
    push(1, 32'h003FFFFF, 10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    while (rel() < 14) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero_outputs("midrst");
    chk("midrst_sb", 64'(sbq.size()), 64'd0);
    sbq.delete();
    @(posedge clk); #1;
    for (int k = 0; k < SC; k++) begin
      push(0, 32'h003FFFFF, 6 + 10 * k);
      push(1, 32'h003FFFFF, 10 + 10 * k);
    end
    run(41, 0, 0, 1'b0, 1'b0, 0, 0, '0);

    // Feedback: a1 written in the start cycle; sel 3 write has no effect.
    rom_mode = 1;
    cfg(0, 0, 32'h0001_0000);
    cfg(0, 3, 32'h1234_5678);
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < SC; k++) begin
        push(0, fb0[k], 6 + 10 * k);
        push(1, 32'h003FFFFF, 10 + 10 * k);
      end
      run(41, 0, 0, 1'b0, (rep == 0), 0, 2, 32'h0000_8000);
    end

    // Negative wrap without saturation.
    rom_mode = 2;
    cfg(0, 0, 32'hFFFF_0000);
    cfg(0, 2, 32'h0000_0000);
    for (int k = 0; k < SC; k++) begin
      push(0, 32'h803FFFFF, 6 + 10 * k);
      push(1, 32'h003FFFFF, 10 + 10 * k);
    end
    run(41, 0, 0, 1'b0, 1'b0, 0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected earlier finish");
    $fatal(1, "timeout");
  end

endmodule
